omp_pixel_frame_tx: RTL and testbench

- Downstream of the OMP reconstruction top. Captures the reconstructed pixel stream (addr/value/write-enable) into a local frame buffer.
- On the frame-done pulse, serialises the whole frame as a byte packet on a valid/ready stream toward the host link (UART/USB bridge).
- Decouples the bursty pixel writes from the slow, back-pressured host interface.

---
 rtl/omp_pixel_frame_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_omp_pixel_frame_tx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omp_pixel_frame_tx.sv
// omp_pixel_frame_tx
// Purpose : captures the reconstructed pixel stream into a frame buffer with a
//           written-mask. On frame_done it sends the frame as one byte packet:
//           HDR0, HDR1, LEN=NPIX-1, NPIX*BPP pixel bytes (ascending address,
//           MSB byte first), then an optional checksum byte.
//           Pixels that were never written are sent as zero bytes.
// Latency : HDR0 is valid the cycle after frame_done is seen in IDLE.
//           Bytes then follow at 1 byte/cycle while tx_ready is high.
// Backpr. : tx_data/tx_valid/tx_last are registered and held while tx_valid & !tx_ready.
//           Pixel writes and frame_done that arrive while busy are dropped and
//           recorded in the sticky wr_drop/frame_drop flags.
// Build   : define OMP_FRAME_CHECKSUM_EN to append a CHK byte (8-bit sum of LEN and
//           all pixel bytes); without it the packet ends on the last pixel byte.
// Ports   : clk, rst_n (async, active-low)
//           pixel_addr/pixel_val/pixel_we  pixel write port (accepted only in IDLE)
//           frame_done (start pulse), clear_err (clears the sticky flags)
//           tx_data/tx_valid/tx_last/tx_ready  byte stream toward the host link
//           busy, missing_cnt (unwritten pixels at packet start), wr_drop, frame_drop
module omp_pixel_frame_tx #(
  parameter int         ADDR_W = 6,
  parameter int         DATA_W = 24,
  parameter logic [7:0] HDR0   = 8'hA5,
  parameter logic [7:0] HDR1   = 8'h5A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pixel_addr,
  input  logic [DATA_W-1:0] pixel_val,
  input  logic              pixel_we,
  input  logic              frame_done,
  input  logic              clear_err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic              busy,
  output logic [ADDR_W:0]   missing_cnt,
  output logic              wr_drop,
  output logic              frame_drop
);

  localparam int                NPIX      = 1 << ADDR_W;
  localparam int                BPP       = DATA_W / 8;
  localparam int                BW        = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NPIX - 1);
  localparam logic [BW-1:0]     LAST_BYTE = BW'(BPP - 1);
  localparam logic [7:0]        LEN_BYTE  = 8'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC0, S_SYNC1, S_LEN, S_PIX
`ifdef OMP_FRAME_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t            r_state;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_tx_last;
  logic              r_busy;
  logic [ADDR_W:0]   r_missing;
  logic              r_wr_drop;
  logic              r_frame_drop;
  logic [NPIX-1:0]   r_mask;
  logic [DATA_W-1:0] r_buf [NPIX];
  logic [ADDR_W-1:0] r_pix;
  logic [BW-1:0]     r_byte;
`ifdef OMP_FRAME_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic              w_idle;
  logic              w_hs;
  logic              w_last_byte;
  logic              w_end_pix;
  logic [NPIX-1:0]   w_written;
  logic [ADDR_W:0]   w_missing;
  logic [ADDR_W-1:0] w_sel_pix;
  logic [BW-1:0]     w_sel_byte;
  logic [DATA_W-1:0] w_sel_val;
  logic [7:0]        w_sel_dat;
  logic              w_sel_final;

  assign w_idle      = (r_state == S_IDLE);
  assign w_hs        = r_tx_valid & tx_ready;
  assign w_last_byte = (r_byte == LAST_BYTE);
  assign w_end_pix   = (r_pix == LAST_PIX) && w_last_byte;

  // Unwritten-pixel count as seen by the start cycle, so a write landing in the
  // same cycle as frame_done already counts as written.
  always_comb begin
    w_written = r_mask;
    if (pixel_we) w_written[pixel_addr] = 1'b1;
    w_missing = '0;
    for (int i = 0; i < NPIX; i++)
      w_missing = w_missing + CNT_W'(~w_written[i]);
  end

  // Position of the byte to load on the next handshake. From LEN this is pixel 0
  // byte 0; from PIX it is the current position advanced by one (wrapping to 0,0
  // after the last byte). Reading ahead keeps tx_data registered with no bubbles.
  always_comb begin
    w_sel_pix  = '0;
    w_sel_byte = '0;
    if (r_state == S_PIX) begin
      w_sel_pix  = w_last_byte ? r_pix + 1'b1 : r_pix;
      w_sel_byte = w_last_byte ? '0 : r_byte + 1'b1;
    end
  end

  // Unwritten pixels read as zero, so stale buffer contents never leave the block.
  always_comb begin
    w_sel_val = r_mask[w_sel_pix] ? r_buf[w_sel_pix] : '0;
    w_sel_dat = '0;
    for (int b = 0; b < BPP; b++)
      if (w_sel_byte == BW'(b)) w_sel_dat = w_sel_val[DATA_W-1-8*b -: 8];
  end

`ifdef OMP_FRAME_CHECKSUM_EN
  assign w_sel_final = 1'b0;
`else
  assign w_sel_final = (w_sel_pix == LAST_PIX) && (w_sel_byte == LAST_BYTE);
`endif

  // Buffer array has no reset; the mask makes its contents irrelevant after reset.
  always_ff @(posedge clk) begin
    if (w_idle && pixel_we) r_buf[pixel_addr] <= pixel_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_last    <= 1'b0;
      r_busy       <= 1'b0;
      r_missing    <= '0;
      r_wr_drop    <= 1'b0;
      r_frame_drop <= 1'b0;
      r_mask       <= '0;
      r_pix        <= '0;
      r_byte       <= '0;
`ifdef OMP_FRAME_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      // A new drop event takes priority over clear_err in the same cycle.
      if (pixel_we && !w_idle)        r_wr_drop <= 1'b1;
      else if (clear_err)             r_wr_drop <= 1'b0;
      if (frame_done && !w_idle)      r_frame_drop <= 1'b1;
      else if (clear_err)             r_frame_drop <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (pixel_we) r_mask[pixel_addr] <= 1'b1;
          if (frame_done) begin
            r_state    <= S_SYNC0;
            r_tx_data  <= HDR0;
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b1;
            r_missing  <= w_missing;
            r_pix      <= '0;
            r_byte     <= '0;
`ifdef OMP_FRAME_CHECKSUM_EN
            r_sum      <= '0;
`endif
          end
        end
        S_SYNC0: if (w_hs) begin
          r_state   <= S_SYNC1;
          r_tx_data <= HDR1;
        end
        S_SYNC1: if (w_hs) begin
          r_state   <= S_LEN;
          r_tx_data <= LEN_BYTE;
        end
        S_LEN: if (w_hs) begin
          r_state   <= S_PIX;
          r_tx_data <= w_sel_dat;
          r_tx_last <= w_sel_final;
          r_pix     <= w_sel_pix;
          r_byte    <= w_sel_byte;
`ifdef OMP_FRAME_CHECKSUM_EN
          r_sum     <= r_sum + r_tx_data;
`endif
        end
        S_PIX: if (w_hs) begin
          r_pix  <= w_sel_pix;
          r_byte <= w_sel_byte;
`ifdef OMP_FRAME_CHECKSUM_EN
          r_sum  <= r_sum + r_tx_data;
          if (w_end_pix) begin
            r_state   <= S_CHK;
            r_tx_data <= r_sum + r_tx_data;
            r_tx_last <= 1'b1;
          end else begin
            r_tx_data <= w_sel_dat;
            r_tx_last <= w_sel_final;
          end
`else
          if (w_end_pix) begin
            r_state    <= S_IDLE;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_mask     <= '0;
          end else begin
            r_tx_data <= w_sel_dat;
            r_tx_last <= w_sel_final;
          end
`endif
        end
`ifdef OMP_FRAME_CHECKSUM_EN
        S_CHK: if (w_hs) begin
          r_state    <= S_IDLE;
          r_tx_data  <= '0;
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
          r_busy     <= 1'b0;
          r_mask     <= '0;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign tx_last     = r_tx_last;
  assign busy        = r_busy;
  assign missing_cnt = r_missing;
  assign wr_drop     = r_wr_drop;
  assign frame_drop  = r_frame_drop;

endmodule

// File: tb/tb_omp_pixel_frame_tx.sv
// Scoreboard bench for omp_pixel_frame_tx. The stimulus side keeps a plain
// array model of the frame (values + written flags); on each accepted frame_done
// it builds the whole expected packet and pushes it into a queue. A monitor on
// the falling edge pops one expected byte per handshake and compares.
module tb_omp_pixel_frame_tx;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 24;
  localparam int NPIX   = 64;
  localparam int BPP    = 3;
`ifdef OMP_FRAME_CHECKSUM_EN
  localparam int PKT_LEN = 3 + NPIX * BPP + 1;
`else
  localparam int PKT_LEN = 3 + NPIX * BPP;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] pixel_addr = '0;
  logic [DATA_W-1:0] pixel_val = '0;
  logic              pixel_we = 1'b0;
  logic              frame_done = 1'b0;
  logic              clear_err = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready = 1'b1;
  logic              busy;
  logic [ADDR_W:0]   missing_cnt;
  logic              wr_drop;
  logic              frame_drop;

  always #5 clk = ~clk;

  omp_pixel_frame_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HDR0(8'hA5), .HDR1(8'h5A)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_addr(pixel_addr), .pixel_val(pixel_val), .pixel_we(pixel_we),
    .frame_done(frame_done), .clear_err(clear_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .missing_cnt(missing_cnt), .wr_drop(wr_drop), .frame_drop(frame_drop)
  );

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
    logic       first;
  } exp_t;

  exp_t              exp_q[$];
  int                exp_miss_q[$];
  logic [DATA_W-1:0] m_buf [NPIX];
  bit                m_mask [NPIX];
  bit                m_busy, e_wr_drop, e_frame_drop;
  int                n_vec, n_err;
  int                pkt_idx, hs_cnt, got_miss;
  logic [7:0]        got_pkt [PKT_LEN];
  bit                prev_stall, idle_chk;
  logic [7:0]        prev_dat;
  int                rdy_mode, stall_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic void push_exp(input logic [7:0] d, input logic l, input logic f);
    exp_t e;
    e.dat = d; e.last = l; e.first = f;
    exp_q.push_back(e);
  endfunction

  // Whole-packet reference built straight from the frame contents.
  task automatic start_packet();
    int         miss;
    logic [7:0] sum, bt;
    miss = 0;
    for (int p = 0; p < NPIX; p++) if (!m_mask[p]) miss++;
    push_exp(8'hA5, 1'b0, 1'b1);
    push_exp(8'h5A, 1'b0, 1'b0);
    push_exp(8'(NPIX - 1), 1'b0, 1'b0);
    sum = 8'(NPIX - 1);
    for (int p = 0; p < NPIX; p++)
      for (int k = 0; k < BPP; k++) begin
        bt = m_mask[p] ? m_buf[p][8*(BPP-1-k) +: 8] : 8'h00;
        sum = sum + bt;
`ifdef OMP_FRAME_CHECKSUM_EN
        push_exp(bt, 1'b0, 1'b0);
`else
        push_exp(bt, (p == NPIX - 1) && (k == BPP - 1), 1'b0);
`endif
      end
`ifdef OMP_FRAME_CHECKSUM_EN
    push_exp(sum, 1'b1, 1'b0);
`endif
    exp_miss_q.push_back(miss);
    for (int p = 0; p < NPIX; p++) m_mask[p] = 1'b0;
    m_busy = 1'b1;
  endtask

  // One clock of input; called just after a rising edge.
  task automatic drive(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v,
                       input bit fd, input bit clr);
    bit b;
    b = m_busy;
    pixel_we = we; pixel_addr = a; pixel_val = v; frame_done = fd; clear_err = clr;
    if (we && b) e_wr_drop = 1'b1; else if (clr) e_wr_drop = 1'b0;
    if (fd && b) e_frame_drop = 1'b1; else if (clr) e_frame_drop = 1'b0;
    if (we && !b) begin m_buf[a] = v; m_mask[a] = 1'b1; end
    if (fd && !b) start_packet();
    @(posedge clk); #1;
    pixel_we = 1'b0; frame_done = 1'b0; clear_err = 1'b0;
    check("wr_drop", wr_drop, e_wr_drop);
    check("frame_drop", frame_drop, e_frame_drop);
    if (fd && !b) begin
      check("start_valid", tx_valid, 1'b1);
      check("start_hdr0", tx_data, 8'hA5);
      check("start_busy", busy, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < 5000) begin
      idle(1);
      n++;
    end
    if (n >= 5000) fail_now("drain_timeout");
    idle(2);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      idle_chk   = 1'b0;
    end else begin
      if (idle_chk) begin
        check("busy_fall", busy, 1'b0);
        check("valid_fall", tx_valid, 1'b0);
        check("handshake_total", hs_cnt, PKT_LEN);
        hs_cnt   = 0;
        idle_chk = 1'b0;
      end
      if (tx_valid) begin
        check("busy_with_valid", busy, 1'b1);
        if (prev_stall) check("hold_stable", tx_data, prev_dat);
        prev_stall = !tx_ready;
        prev_dat   = tx_data;
        if (tx_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_byte");
          end else begin
            e = exp_q.pop_front();
            if (e.first) begin
              pkt_idx  = 0;
              got_miss = int'(missing_cnt);
              if (exp_miss_q.size() != 0) check("missing_cnt", missing_cnt, exp_miss_q.pop_front());
            end
            check("tx_data", tx_data, e.dat);
            check("tx_last", tx_last, e.last);
            if (pkt_idx < PKT_LEN) got_pkt[pkt_idx] = tx_data;
            pkt_idx++;
            if (e.last) begin
              idle_chk = 1'b1;
              m_busy   = 1'b0;
            end
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Sink: always ready, random, or a single 10-cycle stall on the 5th byte.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (busy && pkt_idx == 4 && stall_cnt < 10) begin
          tx_ready = 1'b0;
          stall_cnt++;
        end else begin
          tx_ready = 1'b1;
        end
      end
    endcase
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; pkt_idx = 0; hs_cnt = 0; got_miss = -1;
    m_busy = 1'b0; e_wr_drop = 1'b0; e_frame_drop = 1'b0;
    rdy_mode = 0; stall_cnt = 0;
    for (int p = 0; p < NPIX; p++) begin m_mask[p] = 1'b0; m_buf[p] = '0; end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_last", tx_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_missing", missing_cnt, 7'd0);
    check("rst_wr_drop", wr_drop, 1'b0);
    check("rst_frame_drop", frame_drop, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty frame: all pixels missing, all zero.
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    wait_drain();
    check("empty_missing", got_miss, 64);
    check("empty_hdr1", got_pkt[1], 8'h5A);
    check("empty_len", got_pkt[2], 8'h3F);
    check("empty_pix", got_pkt[100], 8'h00);
`ifdef OMP_FRAME_CHECKSUM_EN
    check("empty_chk", got_pkt[195], 8'h3F);
`endif

    // Full ramp frame.
    for (int i = 0; i < NPIX; i++)
      drive(1'b1, ADDR_W'(i), {8'(i), 8'(i), 8'(i)}, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    wait_drain();
    check("ramp_missing", got_miss, 0);
    check("ramp_pix1", got_pkt[3 + 3], 8'h01);
    check("ramp_pix63", got_pkt[3 + 3 * 63 + 2], 8'h3F);
`ifdef OMP_FRAME_CHECKSUM_EN
    check("ramp_chk", got_pkt[195], 8'hDF);
`endif

    // Single pixel written in the same cycle as frame_done.
    drive(1'b1, ADDR_W'(5), 24'h123456, 1'b1, 1'b0);
    wait_drain();
    check("one_missing", got_miss, 63);
    check("one_b18", got_pkt[18], 8'h12);
    check("one_b19", got_pkt[19], 8'h34);
    check("one_b20", got_pkt[20], 8'h56);
    check("one_b21", got_pkt[21], 8'h00);
`ifdef OMP_FRAME_CHECKSUM_EN
    check("one_chk", got_pkt[195], 8'hDB);
`endif

    // 10-cycle stall on the 5th byte.
    for (int i = 0; i < 8; i++)
      drive(1'b1, ADDR_W'($urandom_range(0, 63)), DATA_W'($urandom), 1'b0, 1'b0);
    pkt_idx = 0; stall_cnt = 0; rdy_mode = 2;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    wait_drain();
    check("stall_cycles", stall_cnt, 10);
    rdy_mode = 0;

    // Drops while busy, clear, set-wins-over-clear, then a fully cleared mask.
    drive(1'b1, ADDR_W'(0), 24'hABCDEF, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(10);
    drive(1'b1, ADDR_W'(0), 24'hFFFFFF, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, ADDR_W'(1), 24'h111111, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    wait_drain();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    wait_drain();
    check("second_missing", got_miss, 64);

    // Reset in the middle of the pixel bytes.
    drive(1'b1, ADDR_W'(9), 24'h0A0B0C, 1'b1, 1'b0);
    idle(20);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", tx_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    exp_q.delete(); exp_miss_q.delete();
    m_busy = 1'b0; e_wr_drop = 1'b0; e_frame_drop = 1'b0; hs_cnt = 0;
    for (int p = 0; p < NPIX; p++) m_mask[p] = 1'b0;
    @(posedge clk); #1;
    check("abort_held_valid", tx_valid, 1'b0);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_quiet", tx_valid, 1'b0);
    drive(1'b1, ADDR_W'(33), 24'h00C0DE, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    wait_drain();
    check("post_rst_hdr0", got_pkt[0], 8'hA5);
    check("post_rst_missing", got_miss, 63);

    // Randomised frames with random backpressure and traffic while busy.
    rdy_mode = 1;
    for (int f = 0; f < 6; f++) begin
      int nw;
      nw = $urandom_range(0, 40);
      for (int i = 0; i < nw; i++)
        drive(1'b1, ADDR_W'($urandom_range(0, 15) * 4), DATA_W'($urandom), 1'b0,
              $urandom_range(0, 7) == 0);
      drive($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 63)), DATA_W'($urandom),
            1'b1, 1'b0);
      for (int i = 0; i < 30; i++)
        drive($urandom_range(0, 3) == 0, ADDR_W'($urandom_range(0, 63)), DATA_W'($urandom),
              $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
      wait_drain();
    end
    rdy_mode = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
